// File: rtl/encoder_pkg.sv
// Shared types and default sizes for the sequential 32-to-5 priority encoder.
package encoder_pkg;

  localparam int ENC_N     = 32;
  localparam int ENC_IDX_W = 5;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_t;

endpackage

// File: rtl/priority_enc32_5.sv
// Combinational priority select: index of the winning set bit, plus any-set and exactly-one-set flags.
// Define PRIORITY_ENCODER_MSB_FIRST_EN to make the highest set bit win instead of the lowest.
module priority_enc32_5
  import encoder_pkg::*;
#(
  parameter int N     = ENC_N,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     i_vec,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_any,
  output logic             o_single
);

  logic [N-1:0] w_vec_minus1;

  assign w_vec_minus1 = i_vec - N'(1);
  assign o_any        = |i_vec;
  // Clearing the lowest set bit leaves zero only when a single bit was set.
  assign o_single     = o_any && ((i_vec & w_vec_minus1) == '0);

  always_comb begin
    o_idx = '0;
`ifdef PRIORITY_ENCODER_MSB_FIRST_EN
    for (int i = 0; i < N; i++) begin
      if (i_vec[i]) o_idx = IDX_W'(i);
    end
`else
    for (int i = N - 1; i >= 0; i--) begin
      if (i_vec[i]) o_idx = IDX_W'(i);
    end
`endif
  end

endmodule

// File: rtl/priority_encoder32_5.sv
// Sequential 32-to-5 encoder: accepts a request mask and emits one index per handshake.
// Emission order follows PRIORITY_ENCODER_MSB_FIRST_EN (undefined: ascending).
module priority_encoder32_5
  import encoder_pkg::*;
#(
  parameter int N     = ENC_N,
  parameter int IDX_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_vec,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic             busy
);

  state_t           r_state;
  state_t           w_state_next;
  logic [N-1:0]     r_pending;
  logic [N-1:0]     w_pending_next;
  logic [IDX_W-1:0] w_idx;
  logic             w_any;
  logic             w_single;
  logic [N-1:0]     w_clear_mask;

  priority_enc32_5 #(
    .N    (N),
    .IDX_W(IDX_W)
  ) u_enc (
    .i_vec   (r_pending),
    .o_idx   (w_idx),
    .o_any   (w_any),
    .o_single(w_single)
  );

  assign w_clear_mask = N'(1) << w_idx;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_pending <= '0;
    end else begin
      r_state   <= w_state_next;
      r_pending <= w_pending_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_pending_next = r_pending;
    in_ready       = 1'b0;
    out_valid      = 1'b0;
    busy           = 1'b0;
    out_idx        = '0;
    out_last       = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        // An all-zero mask is accepted and simply dropped.
        if (in_valid && (in_vec != '0)) begin
          w_pending_next = in_vec;
          w_state_next   = DRAIN;
        end
      end
      DRAIN: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        out_idx   = w_idx;
        out_last  = w_single;
        if (!w_any) begin
          w_state_next = IDLE;
        end else if (out_ready) begin
          w_pending_next = r_pending & ~w_clear_mask;
          if (w_single) w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next   = IDLE;
        w_pending_next = '0;
      end
    endcase
  end

endmodule
